dual_issue_router: RTL

//  Consumer end of the fetch->issue interface. Takes the 64-bit instruction pair from the fetch

---
 rtl/dual_issue_router.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dual_issue_router.sv
// Issue stage behind fetch: classifies each word of an instruction pair to the even or odd pipe
// and issues up to one instruction per pipe per cycle, splitting conflicting pairs over two cycles.
module dual_issue_router #(
  parameter int INST_W = 32,
  parameter int REG_W  = 7,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                pipe_stall,
  input  logic [2*INST_W-1:0] inst_pair,
  output logic                stall,
  output logic [INST_W-1:0]   even_inst,
  output logic                even_valid,
  output logic [INST_W-1:0]   odd_inst,
  output logic                odd_valid,
  output logic [CNT_W-1:0]    issue_count
);

  localparam logic [0:0] ST_ISSUE = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  logic [0:0]        r_state;
  logic [INST_W-1:0] r_even_inst;
  logic [INST_W-1:0] r_odd_inst;
  logic              r_even_valid;
  logic              r_odd_valid;
  logic [CNT_W-1:0]  r_count;

  logic [INST_W-1:0] w_s0;
  logic [INST_W-1:0] w_s1;
  logic [1:0]        w_cls0;
  logic [1:0]        w_cls1;
  logic              w_v0;
  logic              w_v1;
  logic              w_odd0;
  logic              w_odd1;
  logic              w_raw;
  logic              w_conflict;
  logic              w_iss_s0;
  logic              w_iss_s1;
  logic              w_ev;
  logic              w_ov;
  logic [INST_W-1:0] w_ei;
  logic [INST_W-1:0] w_oi;
  logic [1:0]        w_n;
  logic [0:0]        w_next_state;

  assign w_s0   = inst_pair[INST_W-1:0];
  assign w_s1   = inst_pair[2*INST_W-1:INST_W];
  assign w_cls0 = w_s0[INST_W-1:INST_W-2];
  assign w_cls1 = w_s1[INST_W-1:INST_W-2];
  assign w_v0   = (w_s0 != {INST_W{1'b1}});
  assign w_v1   = (w_s1 != {INST_W{1'b1}});
  // Classes 01 and 10 go to the odd pipe, 00 and 11 to the even pipe.
  assign w_odd0 = ^w_cls0;
  assign w_odd1 = ^w_cls1;

  assign w_raw = (w_s1[2*REG_W-1:REG_W]   == w_s0[REG_W-1:0]) ||
                 (w_s1[3*REG_W-1:2*REG_W] == w_s0[REG_W-1:0]);

  // A branch in slot0 always issues alone so slot1 never runs ahead of its resolution.
  assign w_conflict = w_v0 && w_v1 && ((w_odd0 == w_odd1) || w_raw || (w_cls0 == 2'b10));

  assign stall = ~reset & (pipe_stall | ((r_state == ST_ISSUE) & w_conflict & ~flush));

  always_comb begin
    w_iss_s0 = 1'b0;
    w_iss_s1 = 1'b0;
    if (r_state == ST_SPLIT) begin
      w_iss_s1 = w_v1;
    end else if (w_conflict) begin
      w_iss_s0 = 1'b1;
    end else begin
      w_iss_s0 = w_v0;
      w_iss_s1 = w_v1;
    end
  end

  // Without a conflict the two valid slots target different pipes, so no overwrite occurs.
  always_comb begin
    w_ev = 1'b0;
    w_ov = 1'b0;
    w_ei = r_even_inst;
    w_oi = r_odd_inst;
    if (w_iss_s0) begin
      if (w_odd0) begin
        w_ov = 1'b1;
        w_oi = w_s0;
      end else begin
        w_ev = 1'b1;
        w_ei = w_s0;
      end
    end
    if (w_iss_s1) begin
      if (w_odd1) begin
        w_ov = 1'b1;
        w_oi = w_s1;
      end else begin
        w_ev = 1'b1;
        w_ei = w_s1;
      end
    end
  end

  assign w_n          = {1'b0, w_iss_s0} + {1'b0, w_iss_s1};
  assign w_next_state = ((r_state == ST_ISSUE) && w_conflict) ? ST_SPLIT : ST_ISSUE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_ISSUE;
      r_even_inst  <= '0;
      r_odd_inst   <= '0;
      r_even_valid <= 1'b0;
      r_odd_valid  <= 1'b0;
      r_count      <= '0;
    end else if (flush) begin
      r_state      <= ST_ISSUE;
      r_even_valid <= 1'b0;
      r_odd_valid  <= 1'b0;
    end else if (!pipe_stall) begin
      r_state      <= w_next_state;
      r_even_inst  <= w_ei;
      r_odd_inst   <= w_oi;
      r_even_valid <= w_ev;
      r_odd_valid  <= w_ov;
      r_count      <= r_count + CNT_W'(w_n);
    end
  end

  assign even_inst   = r_even_inst;
  assign even_valid  = r_even_valid;
  assign odd_inst    = r_odd_inst;
  assign odd_valid   = r_odd_valid;
  assign issue_count = r_count;

endmodule
